prio_arbiter_enc: RTL and testbench
===================================

// Module: prio_arbiter_enc
// PURPOSE
//   Parametrised, registered N-input priority encoder/arbiter. Next generation of the 4x3
//   combinational priority encoder: any width, run-time fixed or round-robin priority,
//   registered index + one-hot grant, valid/ready handshake with grant hold.
//   Sits between request sources and a single shared consumer (bus, port, datapath).
// PARAMETERS
//   N  4            number of request inputs (N >= 2)
//   W  $clog2(N)    width of encoded index output
// PORTS
//   clk         in   1  clock, all state updates on rising edge
//   rst         in   1  reset, asynchronous, active-high
//   req         in   N  request vector, bit i = source i requesting
//   mode        in   1  0 = fixed priority (highest index wins), 1 = round-robin
//   out_ready   in   1  consumer accepts current grant this cycle
//   out_valid   out  1  grant valid (equivalent of V)
//   out_idx     out  W  encoded index of granted source
//   out_onehot  out  N  one-hot of granted source, zero when out_valid=0
// BEHAVIOUR
//   Reset (async, immediate): out_valid=0, out_idx=0, out_onehot=0, rr_ptr=0, state=IDLE.
//   States: IDLE (no grant held), HOLD (grant presented, awaiting out_ready).
//   IDLE: if |req at edge -> load winner into out_idx/out_onehot, out_valid=1, go HOLD.
//         if req==0 -> stay IDLE, outputs unchanged (out_valid=0, out_onehot=0).
//   Latency: req sampled at edge k -> out_valid high after edge k (1 cycle).
//   HOLD, out_ready=0: out_idx/out_onehot/out_valid frozen; req changes and mode changes
//         ignored until handshake (request is captured, not cancelled by req dropping).
//   HOLD, out_ready=1 (handshake): rr_ptr <= (out_idx+1) mod N (wrap N-1 -> 0);
//         same edge, if |req -> load next winner (back-to-back, stay HOLD, one grant/cycle),
//         computed with the UPDATED pointer; else out_valid=0, out_onehot=0, go IDLE.
//   out_ready while out_valid=0: ignored.
//   Winner selection (combinational, at load edge, mode sampled at that edge):
//     fixed: highest set index of req. rr: first set bit scanning rr_ptr, rr_ptr+1, ...
//     wrapping modulo N. rr_ptr updates on every handshake in both modes, so switching
//     to rr continues fairly from the last grant.
//   Invariants: out_onehot == (out_valid ? 1<<out_idx : 0); out_idx < N.
//   Reset asserted mid-HOLD: grant dropped immediately, no handshake credited, rr_ptr=0.
// STRUCTURE
//   Shared include prio_defs.vh: state encodings ST_IDLE/ST_HOLD, MODE_FIXED=0, MODE_RR=1.
//   Sub-module prio_find_msb #(N,W): combinational, returns highest set index + any flag.
//     fixed: prio_find_msb(req). rr: rotate req right by rr_ptr, bit-reverse so lowest
//     rotated bit is MSB, find, map index back modulo N. One instance per path (two total).
//   Top holds FSM, rr_ptr register, output registers.
// TESTING (N=4)
//   1 mode=0, req=0101, out_ready=0 -> next cycle out_valid=1, out_idx=2, out_onehot=0100.
//   2 hold: keep out_ready=0 3 cycles, change req to 1000 -> out_idx stays 2; then
//     out_ready=1 one cycle -> next cycle out_idx=3 (req=1000), then req=0 + ready -> valid=0.
//   3 mode=1, req=1111, out_ready=1 constant from reset -> out_idx 0,1,2,3,0 one per cycle.
//   4 rr wrap: after grant idx=2 (ptr=3), req=0011 -> out_idx=0; next grant -> out_idx=1.
//   5 req=0000 for 5 cycles, out_ready toggling -> out_valid=0, out_onehot=0000 throughout.
//   6 rst pulse mid-HOLD between edges -> outputs zero immediately, after release with
//     mode=1, req=1010 -> out_idx=1 (ptr reset to 0). Check onehot/idx invariant each cycle.

Source files
------------

// File: rtl/prio_arbiter_enc_pkg.sv
// Shared types and constants for the registered priority arbiter/encoder.
// The FSM state encoding and the priority-mode selector values live here.
package prio_arbiter_enc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_find_msb.sv
// Combinational search for the highest set bit of a vector.
// Reports that bit's index and whether any bit is set.
module prio_find_msb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // The scan runs upward, so the last set bit it meets is the highest.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter_enc.sv
// Registered N-input arbiter with fixed or round-robin priority. A grant is
// held until the consumer handshakes, and back-to-back grants are supported.
module prio_arbiter_enc
    import prio_arbiter_enc_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot
);

    localparam logic [W:0]   N_EXT   = (W+1)'(N);
    localparam logic [W:0]   NM1_EXT = (W+1)'(N-1);
    localparam logic [N-1:0] ONE_N   = N'(1);

    state_t         state_reg, state_next;
    logic [W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic           out_valid_reg, out_valid_next;
    logic [W-1:0]   out_idx_reg, out_idx_next;
    logic [N-1:0]   out_onehot_reg, out_onehot_next;

    logic           handshake;
    logic [W-1:0]   ptr_inc;
    logic [W-1:0]   ptr_eff;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   req_rev;
    logic [W-1:0]   fix_idx, rr_m, rr_idx;
    logic           fix_any, rr_any;
    logic [W:0]     rr_sum;
    logic [W-1:0]   win_idx;
    logic           win_any;

    assign handshake = (state_reg == ST_HOLD) && out_ready;
    assign ptr_inc   = (out_idx_reg == W'(N-1)) ? '0 : out_idx_reg + 1'b1;
    // A back-to-back load must search from the pointer this same handshake installs.
    assign ptr_eff   = handshake ? ptr_inc : rr_ptr_reg;

    prio_find_msb #(.N(N), .W(W)) u_find_fixed (
        .vec (req),
        .idx (fix_idx),
        .any (fix_any)
    );

    // Rotating right by the pointer puts rr_ptr at bit 0; reversing then turns
    // "lowest rotated bit" into "highest bit" so the same finder can be reused.
    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> ptr_eff);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rev
            assign req_rev[gi] = req_rot[N-1-gi];
        end
    endgenerate

    prio_find_msb #(.N(N), .W(W)) u_find_rr (
        .vec (req_rev),
        .idx (rr_m),
        .any (rr_any)
    );

    // Undo the reversal and rotation: original = (N-1-m + ptr) mod N, sum < 2N.
    always_comb begin
        rr_sum = NM1_EXT - {1'b0, rr_m} + {1'b0, ptr_eff};
        if (rr_sum >= N_EXT) begin
            rr_sum = rr_sum - N_EXT;
        end
        rr_idx = rr_sum[W-1:0];
    end

    assign win_idx = (mode == MODE_RR) ? rr_idx : fix_idx;
    assign win_any = (mode == MODE_RR) ? rr_any : fix_any;

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        out_valid_next  = out_valid_reg;
        out_idx_next    = out_idx_reg;
        out_onehot_next = out_onehot_reg;

        if (state_reg == ST_HOLD && out_ready) begin
            rr_ptr_next     = ptr_inc;
            out_valid_next  = 1'b0;
            out_onehot_next = '0;
            state_next      = ST_IDLE;
        end

        if (state_reg == ST_IDLE || handshake) begin
            if (win_any) begin
                out_idx_next    = win_idx;
                out_onehot_next = ONE_N << win_idx;
                out_valid_next  = 1'b1;
                state_next      = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            out_valid_reg  <= 1'b0;
            out_idx_reg    <= '0;
            out_onehot_reg <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            out_valid_reg  <= out_valid_next;
            out_idx_reg    <= out_idx_next;
            out_onehot_reg <= out_onehot_next;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_idx    = out_idx_reg;
    assign out_onehot = out_onehot_reg;

endmodule

// File: tb/tb_prio_arbiter_enc.sv
// Directed-vector bench for prio_arbiter_enc with N=4 and hand-computed grants.
// Outputs are sampled 1 time unit after each rising edge.
module tb_prio_arbiter_enc;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;

    int total;
    int bad;

    prio_arbiter_enc #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    task automatic expect_grant(input string tag, input logic v, input logic [W-1:0] idx,
                                input logic [N-1:0] oh);
        $display("t=%0t %s req=%b mode=%0d rdy=%0d -> valid=%0d idx=%0d onehot=%b",
                 $time, tag, req, mode, out_ready, out_valid, out_idx, out_onehot);
        chk({tag, ".valid"},  {31'b0, out_valid},  {31'b0, v});
        if (v) chk({tag, ".idx"}, {30'b0, out_idx}, {30'b0, idx});
        chk({tag, ".onehot"}, {28'b0, out_onehot}, {28'b0, oh});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req       = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        expect_grant("reset", 1'b0, 2'd0, 4'b0000);
        chk("reset.idx", {30'b0, out_idx}, 32'd0);
        rst = 1'b0;

        // 1: fixed priority, highest index wins
        req = 4'b0101;
        step();
        expect_grant("t1", 1'b1, 2'd2, 4'b0100);

        // 2: grant held while ready low, then handshake reloads
        req = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_grant("t2.hold", 1'b1, 2'd2, 4'b0100);
        end
        out_ready = 1'b1;
        step();
        expect_grant("t2.next", 1'b1, 2'd3, 4'b1000);
        req = 4'b0000;
        step();
        expect_grant("t2.drop", 1'b0, 2'd0, 4'b0000);

        // 3: round-robin from a fresh reset, ready held high
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mode      = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [W-1:0] e;
            e = W'(i % N);
            step();
            expect_grant("t3.rr", 1'b1, e, 4'b0001 << e);
        end

        // 4: wrap past N-1 with sparse requests
        step();
        expect_grant("t4.a", 1'b1, 2'd1, 4'b0010);
        step();
        expect_grant("t4.b", 1'b1, 2'd2, 4'b0100);
        req = 4'b0011;
        step();
        expect_grant("t4.wrap", 1'b1, 2'd0, 4'b0001);
        step();
        expect_grant("t4.next", 1'b1, 2'd1, 4'b0010);

        // 5: no requests, ready toggling (pointer lands at 2)
        req = 4'b0000;
        step();
        expect_grant("t5.drop", 1'b0, 2'd0, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            out_ready = ~out_ready;
            step();
            expect_grant("t5.idle", 1'b0, 2'd0, 4'b0000);
        end

        // 6: async reset mid-HOLD clears outputs and pointer
        out_ready = 1'b0;
        req = 4'b1010;
        step();
        expect_grant("t6.pre", 1'b1, 2'd3, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        expect_grant("t6.rst", 1'b0, 2'd0, 4'b0000);
        chk("t6.rst.idx", {30'b0, out_idx}, 32'd0);
        #1;
        rst = 1'b0;
        step();
        expect_grant("t6.post", 1'b1, 2'd1, 4'b0010);

        // back-to-back into fixed mode
        mode      = 1'b0;
        out_ready = 1'b1;
        step();
        expect_grant("t6.fixed", 1'b1, 2'd3, 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
